// File: rtl/umtrx_dispatch_demux.sv
// Fans the dispatcher's fifo36 stream out to one of PORTS sinks by destination index,
// or discards it; keeps per-port forwarded-packet counters and a drop counter.

module umtrx_dispatch_port_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt + 16'd1;
  end
endmodule

module umtrx_dispatch_demux #(
  parameter int BASE       = 0,
  parameter int PORTS      = 4,
  parameter int DROP_INDEX = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  input  logic [35:0]           inp_data,
  input  logic                  inp_valid,
  output logic                  inp_ready,
  input  logic [7:0]            inp_dest,
  output logic [35:0]           out_data,
  output logic [PORTS-1:0]      out_valid,
  input  logic [PORTS-1:0]      out_ready,
  output logic [16*PORTS-1:0]   pkt_count,
  output logic [15:0]           drop_count
);
  localparam int IW = (PORTS > 2) ? $clog2(PORTS) : 1;
  localparam logic [IW-1:0] DROP_SEL = IW'(DROP_INDEX);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                       state, state_nxt;
  logic [IW-1:0]                dest, dest_nxt;
  logic [PORTS-1:0]             mask;
  logic [(1<<IW)-1:0]           mask_ext;
  logic                         soft_rst, sof, eof, reject, drop_inc;
  logic [PORTS-1:0]             pkt_inc;
  logic [PORTS-1:0][15:0]       cnt;
  logic                         unused_set;

  assign soft_rst   = rst | clr;
  assign sof        = inp_data[32];
  assign eof        = inp_data[33];
  assign out_data   = inp_data;
  assign mask_ext   = (1<<IW)'(mask);
  assign unused_set = &{1'b0, set_data[31:PORTS]};

  // Out-of-range indices are rejected before the mask lookup matters.
  assign reject = (inp_dest >= 8'(PORTS)) || (inp_dest == 8'(DROP_INDEX)) ||
                  !mask_ext[inp_dest[IW-1:0]];

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    inp_ready = 1'b0;
    out_valid = '0;
    pkt_inc   = '0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        // SOF beat is only inspected here; ROUTE/DROP consume it next cycle.
        if (inp_valid) begin
          if (sof) begin
            dest_nxt  = inp_dest[IW-1:0];
            state_nxt = reject ? DROP : ROUTE;
          end else begin
            state_nxt = DROP;
          end
        end
      end
      ROUTE: begin
        out_valid[dest] = inp_valid;
        inp_ready       = out_ready[dest];
        if (inp_valid && out_ready[dest] && eof) begin
          pkt_inc[dest] = 1'b1;
          state_nxt     = IDLE;
        end
      end
      DROP: begin
        inp_ready = 1'b1;
        if (inp_valid && eof) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state <= IDLE;
      dest  <= DROP_SEL;
    end else begin
      state <= state_nxt;
      dest  <= dest_nxt;
    end
  end

  // Mask survives clr; a write racing the IDLE latch is seen only next cycle.
  always_ff @(posedge clk) begin
    if (rst)                                   mask <= '1;
    else if (set_stb && set_addr == 8'(BASE))  mask <= set_data[PORTS-1:0];
  end

  always_ff @(posedge clk) begin
    if (soft_rst)      drop_count <= '0;
    else if (drop_inc) drop_count <= drop_count + 16'd1;
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    umtrx_dispatch_port_cnt u_cnt (
      .clk (clk),
      .rst (soft_rst),
      .inc (pkt_inc[i]),
      .cnt (cnt[i])
    );
  end

  assign pkt_count = cnt;

endmodule

// File: tb/tb_umtrx_dispatch_demux.sv
// Scoreboard bench for umtrx_dispatch_demux: directed scenarios plus randomized packets
// checked against a packet-level routing model.

module tb_umtrx_dispatch_demux;
  localparam int PORTS = 4;

  logic        clk = 0;
  logic        rst = 1, clr = 0;
  logic        set_stb = 0;
  logic [7:0]  set_addr = 0;
  logic [31:0] set_data = 0;
  logic [35:0] inp_data = 0;
  logic        inp_valid = 0;
  logic        inp_ready;
  logic [7:0]  inp_dest = 0;
  logic [35:0] out_data;
  logic [PORTS-1:0] out_valid;
  logic [PORTS-1:0] out_ready = '1;
  logic [16*PORTS-1:0] pkt_count;
  logic [15:0] drop_count;

  umtrx_dispatch_demux #(.BASE(0), .PORTS(PORTS), .DROP_INDEX(0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready), .inp_dest(inp_dest),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [35:0] exp_q[PORTS][$];
  int exp_pkt[PORTS];
  int exp_drop = 0;
  logic [3:0] tb_mask = 4'hF;
  int rdy_mode = 0;           // 0 hold, 1 random, 2 port1 pattern 1,0,0,1 with port3 ready
  int pidx = 0;
  logic [3:0] pat_bits = 4'b1001;
  logic [35:0] mon_e;
  logic [35:0] cl_d[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Sink readiness generator
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: out_ready = 4'($urandom);
      2: begin out_ready = {1'b1, 1'b0, pat_bits[pidx % 4], 1'b0}; pidx++; end
      default: ;
    endcase
  end

  // Monitor: pops expected beats whenever a port handshakes
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PORTS; i++) begin
        if (out_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_valid port=%0d actual_data=%h required=none", i, out_data);
          end else if (out_ready[i]) begin
            mon_e = exp_q[i].pop_front();
            chk($sformatf("beat_p%0d", i), 64'(out_data), 64'(mon_e));
          end
        end
      end
      if (rdy_mode == 2 && out_valid[1]) chk("rdy_follow", 64'(inp_ready), 64'(out_ready[1]));
    end
  end

  task automatic send_beat(input logic [35:0] d, input logic [7:0] dst, output int cyc);
    logic ok;
    inp_data = d; inp_dest = dst; inp_valid = 1; cyc = 0;
    do begin
      @(negedge clk); cyc++; ok = inp_ready;
      @(posedge clk); #1;
    end while (!ok && cyc < 200);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_timeout actual=%0d cycles required=accept", cyc);
    end
    inp_valid = 0;
  endtask

  function automatic logic [35:0] mk_beat(input int b, input int len, input bit sof);
    logic [35:0] d;
    d[31:0]  = $urandom;
    d[32]    = sof && (b == 0);
    d[33]    = (b == len - 1);
    d[35:34] = 2'(b);
    return d;
  endfunction

  task automatic send_pkt(input int dest, input int len, input bit sof, input bit gaps,
                          output int cyc_total);
    logic [35:0] d[$];
    bit routed;
    int c;
    routed = sof && dest < PORTS && dest != 0 && tb_mask[dest];
    for (int b = 0; b < len; b++) begin
      d.push_back(mk_beat(b, len, sof));
      if (routed) exp_q[dest].push_back(d[b]);
    end
    if (routed) exp_pkt[dest]++; else exp_drop++;
    cyc_total = 0;
    for (int b = 0; b < len; b++) begin
      send_beat(d[b], (b == 0) ? 8'(dest) : 8'($urandom), c);
      cyc_total += c;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      if (gaps) #1;
    end
  endtask

  task automatic write_set(input logic [7:0] a, input logic [31:0] v);
    set_stb = 1; set_addr = a; set_data = v;
    @(posedge clk); #1;
    set_stb = 0;
    if (a == 8'd0) tb_mask = v[3:0];
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    for (int i = 0; i < PORTS; i++) begin
      chk($sformatf("%s_drain_p%0d", tag, i), 64'(exp_q[i].size()), 64'd0);
      chk($sformatf("%s_pkt_p%0d", tag, i), 64'(pkt_count[16*i +: 16]), 64'(16'(exp_pkt[i])));
    end
    chk($sformatf("%s_drop", tag), 64'(drop_count), 64'(16'(exp_drop)));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, tot;
    for (int i = 0; i < PORTS; i++) exp_pkt[i] = 0;

    // Reset with an SOF beat already waiting
    inp_valid = 1; inp_data = 36'h1_0000_0000; inp_dest = 8'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inp_ready", 64'(inp_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    rst = 0; inp_valid = 0;
    @(posedge clk); #1;

    // 5-beat packet to port 2, all ready: one bubble then 5 beats
    rdy_mode = 0; out_ready = '1;
    send_pkt(2, 5, 1, 0, tot);
    chk("p2_cycles", 64'(tot), 64'd6);
    check_counts("s1");

    // Port 1 with toggling readiness, port 3 always ready
    rdy_mode = 2; pidx = 0;
    send_pkt(1, 6, 1, 0, tot);
    rdy_mode = 0; out_ready = '1;
    check_counts("s2");

    // Orphan sequence then a valid port-1 packet
    send_pkt(1, 3, 0, 0, tot);
    send_pkt(1, 4, 1, 0, tot);
    check_counts("s4");

    // Back-to-back single-beat packets to port 3: two cycles each
    tot = 0;
    for (int k = 0; k < 10; k++) begin
      send_pkt(3, 1, 1, 0, cyc);
      tot += cyc;
    end
    chk("single_cycles", 64'(tot), 64'd20);
    check_counts("s5");

    // Drops: DROP_INDEX, out-of-range, masked port; non-BASE write ignored
    send_pkt(0, 3, 1, 0, tot);
    send_pkt(7, 2, 1, 0, tot);
    write_set(8'd5, 32'h0);
    write_set(8'd0, 32'h7);
    send_pkt(3, 3, 1, 0, tot);
    send_pkt(2, 2, 1, 0, tot);
    check_counts("s3");

    // clr on the third beat of an 8-beat packet to port 2
    for (int b = 0; b < 8; b++) cl_d[b] = mk_beat(b, 8, 1);
    for (int b = 0; b < 3; b++) exp_q[2].push_back(cl_d[b]);
    send_beat(cl_d[0], 8'd2, cyc);
    send_beat(cl_d[1], 8'd9, cyc);
    clr = 1;
    send_beat(cl_d[2], 8'd9, cyc);
    clr = 0;
    for (int i = 0; i < PORTS; i++) exp_pkt[i] = 0;
    exp_drop = 0;
    for (int b = 3; b < 8; b++) send_beat(cl_d[b], 8'd2, cyc);
    exp_drop = 1;
    check_counts("s6");
    send_pkt(3, 2, 1, 0, tot);   // mask 0111 must have survived clr
    check_counts("s6m");

    // Randomized traffic
    rdy_mode = 1;
    write_set(8'd0, 32'hF);
    for (int k = 0; k < 60; k++) begin
      int r;
      if ($urandom_range(0, 4) == 0)
        write_set(($urandom_range(0, 2) == 0) ? 8'd3 : 8'd0, $urandom);
      r = $urandom_range(0, 9);
      send_pkt((r < 8) ? r : 1, $urandom_range(1, 6), $urandom_range(0, 9) != 0, 1, tot);
    end
    rdy_mode = 0; out_ready = '1;
    check_counts("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
